// File: rtl/gticc_qpll_rst_seq_pkg.sv
// Shared types and helpers for the GTX QPLL reset/lock sequencer.
// State encodings are fixed because they are exported on the debug port.
package gticc_qpll_pkg;

  typedef enum logic [2:0] {
    ST_PD_HOLD     = 3'd0,
    ST_RESET_HOLD  = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_LOCK_STABLE = 3'd3,
    ST_READY       = 3'd4,
    ST_FAIL        = 3'd5
  } state_e;

  // One bit of headroom above the widest cycle count keeps compares unsigned-safe.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gticc_qpll_rst_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear, for slow
// level signals crossing into clk (no handshake, no pulse capture).
module gticc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gticc_qpll_rst_seq.sv
// Power-down / reset / lock-supervision sequencer for the GTX QPLL common block.
// Outputs are registered from the next state so they move with the state register.
module gticc_qpll_rst_seq
  import gticc_qpll_pkg::*;
#(
  parameter int PD_CYCLES     = 64,
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_reset,
  input  logic       qplllock,
  input  logic       qpllrefclklost,
  output logic       qpllpd,
  output logic       qpllreset,
  output logic       qpll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int CW = cnt_width(PD_CYCLES, RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] PD_LAST  = CW'(PD_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s counts as the first stable cycle.
  localparam logic [CW-1:0] STB_LAST = CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  logic [1:0] sync_in;
  logic [1:0] sync_out;
  logic       lock_s;
  logic       lost_s;

  assign sync_in = {qpllrefclklost, qplllock};

  gticc_sync2 #(.W(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sync_in),
    .q     (sync_out)
  );

  assign lock_s = sync_out[0];
  assign lost_s = sync_out[1];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pd_q, pd_d;
  logic          rst_q, rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PD_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      pd_q    <= 1'b1;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      pd_q    <= pd_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  // Event priority: soft_reset > lost_s > timeout > lock_s.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (soft_reset) begin
      state_d = ST_PD_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PD_HOLD: begin
          if (cnt_q == PD_LAST) state_d = ST_RESET_HOLD;
        end
        ST_RESET_HOLD: begin
          if (lost_s) cnt_d = '0;
          else if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lost_s) begin
            state_d = ST_RESET_HOLD;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET_HOLD;
          end else if (lock_s) begin
            state_d = ST_LOCK_STABLE;
          end
        end
        ST_LOCK_STABLE: begin
          if (lost_s) begin
            state_d = ST_RESET_HOLD;
          end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_READY;
            retry_d = '0;
          end
        end
        ST_READY: begin
          if (lost_s || !lock_s) begin
            state_d = ST_RESET_HOLD;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PD_HOLD;
        end
      endcase
    end

    if (state_d != state_q) cnt_d = '0;

    pd_d    = (state_d == ST_PD_HOLD) || (state_d == ST_FAIL);
    rst_d   = (state_d == ST_PD_HOLD) || (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
    ready_d = (state_d == ST_READY);
    fail_d  = (state_d == ST_FAIL);
  end

  assign qpllpd        = pd_q;
  assign qpllreset     = rst_q;
  assign qpll_ready    = ready_q;
  assign fail          = fail_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule

// File: tb/tb_gticc_qpll_rst_seq.sv
// Directed bench for the QPLL sequencer using short cycle parameters.
module tb_gticc_qpll_rst_seq;

  localparam int PD_CYCLES     = 4;
  localparam int RST_CYCLES    = 3;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 5;
  localparam int MAX_RETRIES   = 2;

  localparam logic [2:0] S_PD  = 3'd0;
  localparam logic [2:0] S_RH  = 3'd1;
  localparam logic [2:0] S_WL  = 3'd2;
  localparam logic [2:0] S_LS  = 3'd3;
  localparam logic [2:0] S_RDY = 3'd4;
  localparam logic [2:0] S_FL  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_reset = 1'b0;
  logic       qplllock = 1'b0;
  logic       qpllrefclklost = 1'b0;
  logic       qpllpd;
  logic       qpllreset;
  logic       qpll_ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gticc_qpll_rst_seq #(
    .PD_CYCLES     (PD_CYCLES),
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .soft_reset     (soft_reset),
    .qplllock       (qplllock),
    .qpllrefclklost (qpllrefclklost),
    .qpllpd         (qpllpd),
    .qpllreset      (qpllreset),
    .qpll_ready     (qpll_ready),
    .fail           (fail),
    .retry_cnt      (retry_cnt),
    .lock_loss_cnt  (lock_loss_cnt),
    .state          (state)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    soft_reset = 1'b0;
    qplllock = 1'b0;
    qpllrefclklost = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int bound, output int waited);
    waited = 0;
    while (state !== target && waited < bound) begin
      cyc();
      waited++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    cyc();
    checks++; if (state !== S_PD) begin errors++; $display("FAIL reset_state: got %0d exp %0d", state, S_PD); end
    checks++; if (qpllpd !== 1'b1 || qpllreset !== 1'b1) begin errors++; $display("FAIL reset_pd_rst: got pd=%b rst=%b exp 1 1", qpllpd, qpllreset); end
    checks++; if (qpll_ready !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_ready_fail: got ready=%b fail=%b exp 0 0", qpll_ready, fail); end
    checks++; if (retry_cnt !== 4'd0 || lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts: got retry=%0d loss=%0d exp 0 0", retry_cnt, lock_loss_cnt); end
    // Leave reset, reach RESET_HOLD, then assert rst_n between edges.
    rst_n = 1'b1;
    repeat (5) cyc();
    checks++; if (state !== S_RH) begin errors++; $display("FAIL reset_pre_async: got %0d exp %0d", state, S_RH); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== S_PD || qpllpd !== 1'b1) begin errors++; $display("FAIL reset_async: got state=%0d pd=%b exp %0d 1", state, qpllpd, S_PD); end
  endtask

  task automatic test_nominal();
    int n;
    do_reset();
    n = 0;
    while (qpllpd === 1'b1 && n < 100) begin cyc(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL nom_pd_width: got %0d exp 4", n); end
    checks++; if (state !== S_RH || qpllreset !== 1'b1) begin errors++; $display("FAIL nom_rh_entry: got state=%0d rst=%b exp %0d 1", state, qpllreset, S_RH); end
    n = 0;
    while (qpllreset === 1'b1 && qpllpd === 1'b0 && n < 100) begin cyc(); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL nom_rst_width: got %0d exp 3", n); end
    checks++; if (state !== S_WL) begin errors++; $display("FAIL nom_wl_entry: got %0d exp %0d", state, S_WL); end
    repeat (10) cyc();
    checks++; if (state !== S_WL || qpll_ready !== 1'b0) begin errors++; $display("FAIL nom_wl_hold: got state=%0d ready=%b exp %0d 0", state, qpll_ready, S_WL); end
    qplllock = 1'b1;
    n = 0;
    while (qpll_ready !== 1'b1 && n < 50) begin cyc(); n++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL nom_ready_latency: got %0d exp 7", n); end
    checks++; if (state !== S_RDY || retry_cnt !== 4'd0) begin errors++; $display("FAIL nom_ready_state: got state=%0d retry=%0d exp %0d 0", state, retry_cnt, S_RDY); end
    checks++; if (qpllpd !== 1'b0 || qpllreset !== 1'b0) begin errors++; $display("FAIL nom_ready_pd_rst: got pd=%b rst=%b exp 0 0", qpllpd, qpllreset); end
  endtask

  task automatic test_loss_in_ready();
    int n;
    qplllock = 1'b0;
    n = 0;
    while (qpll_ready === 1'b1 && n < 20) begin cyc(); n++; end
    checks++; if (n !== 3) begin errors++; $display("FAIL loss_ready_fall: got %0d exp 3", n); end
    checks++; if (state !== S_RH || qpllreset !== 1'b1) begin errors++; $display("FAIL loss_to_rh: got state=%0d rst=%b exp %0d 1", state, qpllreset, S_RH); end
    checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL loss_cnt: got %0d exp 1", lock_loss_cnt); end
    qplllock = 1'b1;
    wait_state(S_RDY, 60, n);
    checks++; if (state !== S_RDY || qpll_ready !== 1'b1) begin errors++; $display("FAIL loss_relock: got state=%0d ready=%b exp %0d 1", state, qpll_ready, S_RDY); end
    checks++; if (lock_loss_cnt !== 8'd1 || retry_cnt !== 4'd0) begin errors++; $display("FAIL loss_relock_cnts: got loss=%0d retry=%0d exp 1 0", lock_loss_cnt, retry_cnt); end
  endtask

  task automatic test_timeout_fail();
    int n;
    int bad;
    qplllock = 1'b0;
    wait_state(S_WL, 40, n);
    checks++; if (state !== S_WL) begin errors++; $display("FAIL to_first_wl: got %0d exp %0d", state, S_WL); end
    checks++; if (lock_loss_cnt !== 8'd2 || retry_cnt !== 4'd0) begin errors++; $display("FAIL to_start_cnts: got loss=%0d retry=%0d exp 2 0", lock_loss_cnt, retry_cnt); end
    n = 0;
    while (state === S_WL && n < 100) begin cyc(); n++; end
    checks++; if (n !== 20) begin errors++; $display("FAIL to_window1: got %0d exp 20", n); end
    checks++; if (state !== S_RH || retry_cnt !== 4'd1) begin errors++; $display("FAIL to_retry1: got state=%0d retry=%0d exp %0d 1", state, retry_cnt, S_RH); end
    wait_state(S_WL, 20, n);
    n = 0;
    while (state === S_WL && n < 100) begin cyc(); n++; end
    checks++; if (n !== 20) begin errors++; $display("FAIL to_window2: got %0d exp 20", n); end
    checks++; if (state !== S_FL || retry_cnt !== 4'd2) begin errors++; $display("FAIL to_fail_state: got state=%0d retry=%0d exp %0d 2", state, retry_cnt, S_FL); end
    checks++; if (fail !== 1'b1 || qpllpd !== 1'b1 || qpllreset !== 1'b1 || qpll_ready !== 1'b0) begin errors++; $display("FAIL to_fail_outs: got fail=%b pd=%b rst=%b ready=%b exp 1 1 1 0", fail, qpllpd, qpllreset, qpll_ready); end
    bad = 0;
    repeat (100) begin
      cyc();
      if (state !== S_FL || fail !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_fail_sticky: got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_soft_reset();
    int n;
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    checks++; if (state !== S_PD || qpllpd !== 1'b1 || qpllreset !== 1'b1) begin errors++; $display("FAIL sr_from_fail: got state=%0d pd=%b rst=%b exp %0d 1 1", state, qpllpd, qpllreset, S_PD); end
    checks++; if (fail !== 1'b0 || retry_cnt !== 4'd0) begin errors++; $display("FAIL sr_clears: got fail=%b retry=%0d exp 0 0", fail, retry_cnt); end
    checks++; if (lock_loss_cnt !== 8'd2) begin errors++; $display("FAIL sr_loss_kept: got %0d exp 2", lock_loss_cnt); end
    wait_state(S_WL, 40, n);
    repeat (LOCK_TIMEOUT - 1) cyc();
    checks++; if (state !== S_WL || retry_cnt !== 4'd0) begin errors++; $display("FAIL sr_pre_timeout: got state=%0d retry=%0d exp %0d 0", state, retry_cnt, S_WL); end
    soft_reset = 1'b1;
    cyc();
    checks++; if (state !== S_PD || retry_cnt !== 4'd0) begin errors++; $display("FAIL sr_beats_timeout: got state=%0d retry=%0d exp %0d 0", state, retry_cnt, S_PD); end
    repeat (5) cyc();
    checks++; if (state !== S_PD || qpllpd !== 1'b1) begin errors++; $display("FAIL sr_held: got state=%0d pd=%b exp %0d 1", state, qpllpd, S_PD); end
    soft_reset = 1'b0;
    n = 0;
    while (qpllpd === 1'b1 && n < 100) begin cyc(); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL sr_pd_width: got %0d exp 4", n); end
  endtask

  task automatic test_lock_chatter();
    int n;
    int bad_ready;
    int bad_retry;
    do_reset();
    wait_state(S_WL, 40, n);
    checks++; if (state !== S_WL) begin errors++; $display("FAIL ch_wl: got %0d exp %0d", state, S_WL); end
    bad_ready = 0;
    qplllock = 1'b1;
    repeat (3) begin cyc(); if (qpll_ready !== 1'b0) bad_ready++; end
    checks++; if (state !== S_LS) begin errors++; $display("FAIL ch_stable: got %0d exp %0d", state, S_LS); end
    qplllock = 1'b0;
    repeat (3) begin cyc(); if (qpll_ready !== 1'b0) bad_ready++; end
    checks++; if (state !== S_WL || retry_cnt !== 4'd0) begin errors++; $display("FAIL ch_back_wl: got state=%0d retry=%0d exp %0d 0", state, retry_cnt, S_WL); end
    bad_retry = 0;
    repeat (LOCK_TIMEOUT - 1) begin
      cyc();
      if (retry_cnt !== 4'd0) bad_retry++;
      if (qpll_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_retry !== 0 || state !== S_WL) begin errors++; $display("FAIL ch_no_early_retry: got bad=%0d state=%0d exp 0 %0d", bad_retry, state, S_WL); end
    cyc();
    checks++; if (retry_cnt !== 4'd1 || state !== S_RH) begin errors++; $display("FAIL ch_timeout: got retry=%0d state=%0d exp 1 %0d", retry_cnt, state, S_RH); end
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL ch_never_ready: got %0d ready cycles exp 0", bad_ready); end
  endtask

  task automatic test_refclk_lost();
    int n;
    do_reset();
    wait_state(S_RH, 20, n);
    checks++; if (state !== S_RH) begin errors++; $display("FAIL rl_rh: got %0d exp %0d", state, S_RH); end
    qpllrefclklost = 1'b1;
    n = 0;
    while (qpllreset === 1'b1 && n < 100) begin
      cyc();
      n++;
      if (n == 10) qpllrefclklost = 1'b0;
    end
    checks++; if (n !== 15) begin errors++; $display("FAIL rl_rst_width: got %0d exp 15", n); end
    checks++; if (state !== S_WL || retry_cnt !== 4'd0) begin errors++; $display("FAIL rl_after: got state=%0d retry=%0d exp %0d 0", state, retry_cnt, S_WL); end
  endtask

  initial begin
    #1;
    test_reset();
    test_nominal();
    test_loss_in_ready();
    test_timeout_fail();
    test_soft_reset();
    test_lock_chatter();
    test_refclk_lost();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
